lc3_mem_responder: RTL and testbench

LC3_MEM_RESPONDER -- requirements
Module: lc3_mem_responder

---
 rtl/lc3_mem_responder.sv | 221 ++++++++++++++++++++++
 tb/tb_lc3_mem_responder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_responder.sv
// Unified-memory responder for an LC3 core: one instruction port and one data
// port, each with programmable wait states, plus a preload write port.
module lc3_mem_responder #(
  parameter int AW    = 12,
  parameter int LAT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [15:0]      pc,
  input  logic             instrmem_rd,
  output logic [15:0]      Instr_dout,
  output logic             complete_instr,
  input  logic             Data_en,
  input  logic [15:0]      Data_addr,
  input  logic             Data_rd,
  input  logic [15:0]      Data_din,
  output logic [15:0]      Data_dout,
  output logic             complete_data,
  input  logic [LAT_W-1:0] cfg_instr_lat,
  input  logic [LAT_W-1:0] cfg_data_lat,
  input  logic             load_en,
  input  logic [15:0]      load_addr,
  input  logic [15:0]      load_data,
  output logic [15:0]      instr_cnt,
  output logic [15:0]      data_cnt
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  logic [15:0] mem_q [DEPTH];

  // ---------------------------------------------------------------- instruction port
  state_e           i_state_q, i_state_d;
  logic [LAT_W-1:0] i_cnt_q, i_cnt_d;
  logic [AW-1:0]    i_addr_q, i_addr_d;
  logic [15:0]      i_dout_q, i_dout_d;
  logic [15:0]      instr_cnt_q, instr_cnt_d;
  logic             i_fire;
  logic [AW-1:0]    i_acc_addr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      i_state_q   <= S_IDLE;
      i_cnt_q     <= '0;
      i_addr_q    <= '0;
      i_dout_q    <= 16'h0000;
      instr_cnt_q <= 16'h0000;
    end else begin
      i_state_q   <= i_state_d;
      i_cnt_q     <= i_cnt_d;
      i_addr_q    <= i_addr_d;
      i_dout_q    <= i_dout_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  // IDLE and DONE share the accept path so back-to-back zero-latency fetches stream.
  always_comb begin
    i_state_d  = i_state_q;
    i_cnt_d    = i_cnt_q;
    i_addr_d   = i_addr_q;
    i_fire     = 1'b0;
    i_acc_addr = i_addr_q;
    case (i_state_q)
      S_WAIT: begin
        if (i_cnt_q == LAT_W'(1)) begin
          i_state_d = S_DONE;
          i_fire    = 1'b1;
        end else begin
          i_cnt_d = i_cnt_q - LAT_W'(1);
        end
      end
      default: begin
        if (instrmem_rd) begin
          i_addr_d = pc[AW-1:0];
          i_cnt_d  = cfg_instr_lat;
          if (cfg_instr_lat == '0) begin
            i_state_d  = S_DONE;
            i_fire     = 1'b1;
            i_acc_addr = pc[AW-1:0];
          end else begin
            i_state_d = S_WAIT;
          end
        end else begin
          i_state_d = S_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    i_dout_d    = i_dout_q;
    instr_cnt_d = instr_cnt_q;
    if (i_fire) begin
      i_dout_d    = mem_q[i_acc_addr];
      instr_cnt_d = instr_cnt_q + 16'd1;
    end
  end

  // ---------------------------------------------------------------- data port
  state_e           d_state_q, d_state_d;
  logic [LAT_W-1:0] d_cnt_q, d_cnt_d;
  logic [AW-1:0]    d_addr_q, d_addr_d;
  logic             d_rd_q, d_rd_d;
  logic [15:0]      d_din_q, d_din_d;
  logic [15:0]      d_dout_q, d_dout_d;
  logic [15:0]      data_cnt_q, data_cnt_d;
  logic             d_fire;
  logic [AW-1:0]    d_acc_addr;
  logic             d_acc_rd;
  logic [15:0]      d_acc_din;
  logic             d_we;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      d_state_q  <= S_IDLE;
      d_cnt_q    <= '0;
      d_addr_q   <= '0;
      d_rd_q     <= 1'b0;
      d_din_q    <= 16'h0000;
      d_dout_q   <= 16'h0000;
      data_cnt_q <= 16'h0000;
    end else begin
      d_state_q  <= d_state_d;
      d_cnt_q    <= d_cnt_d;
      d_addr_q   <= d_addr_d;
      d_rd_q     <= d_rd_d;
      d_din_q    <= d_din_d;
      d_dout_q   <= d_dout_d;
      data_cnt_q <= data_cnt_d;
    end
  end

  always_comb begin
    d_state_d  = d_state_q;
    d_cnt_d    = d_cnt_q;
    d_addr_d   = d_addr_q;
    d_rd_d     = d_rd_q;
    d_din_d    = d_din_q;
    d_fire     = 1'b0;
    d_acc_addr = d_addr_q;
    d_acc_rd   = d_rd_q;
    d_acc_din  = d_din_q;
    case (d_state_q)
      S_WAIT: begin
        if (d_cnt_q == LAT_W'(1)) begin
          d_state_d = S_DONE;
          d_fire    = 1'b1;
        end else begin
          d_cnt_d = d_cnt_q - LAT_W'(1);
        end
      end
      default: begin
        if (Data_en) begin
          d_addr_d = Data_addr[AW-1:0];
          d_rd_d   = Data_rd;
          d_din_d  = Data_din;
          d_cnt_d  = cfg_data_lat;
          if (cfg_data_lat == '0) begin
            d_state_d  = S_DONE;
            d_fire     = 1'b1;
            d_acc_addr = Data_addr[AW-1:0];
            d_acc_rd   = Data_rd;
            d_acc_din  = Data_din;
          end else begin
            d_state_d = S_WAIT;
          end
        end else begin
          d_state_d = S_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    d_dout_d   = d_dout_q;
    data_cnt_d = data_cnt_q;
    d_we       = 1'b0;
    if (d_fire) begin
      data_cnt_d = data_cnt_q + 16'd1;
      if (d_acc_rd) begin
        d_dout_d = mem_q[d_acc_addr];
      end else begin
        d_we = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- storage
  // Preload is written last so it wins over a data write to the same word.
  // Data writes are suppressed while reset is held so an aborted access never lands.
  always_ff @(posedge clock) begin
    if (d_we && reset) begin
      mem_q[d_acc_addr] <= d_acc_din;
    end
    if (load_en) begin
      mem_q[load_addr[AW-1:0]] <= load_data;
    end
  end

  generate
    if (AW < 16) begin : g_alias
      logic unused_hi_bits;
      assign unused_hi_bits = ^{pc[15:AW], Data_addr[15:AW], load_addr[15:AW]};
    end
  endgenerate

  assign Instr_dout     = i_dout_q;
  assign complete_instr = (i_state_q == S_DONE);
  assign instr_cnt      = instr_cnt_q;
  assign Data_dout      = d_dout_q;
  assign complete_data  = (d_state_q == S_DONE);
  assign data_cnt       = data_cnt_q;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Self-checking bench for lc3_mem_responder: directed scenarios plus randomized
// concurrent transactions against a transaction-level memory model.
module tb_lc3_mem_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic        instrmem_rd;
  logic [15:0] Instr_dout;
  logic        complete_instr;
  logic        Data_en;
  logic [15:0] Data_addr;
  logic        Data_rd;
  logic [15:0] Data_din;
  logic [15:0] Data_dout;
  logic        complete_data;
  logic [3:0]  cfg_instr_lat;
  logic [3:0]  cfg_data_lat;
  logic        load_en;
  logic [15:0] load_addr;
  logic [15:0] load_data;
  logic [15:0] instr_cnt;
  logic [15:0] data_cnt;

  lc3_mem_responder #(.AW(12), .LAT_W(4)) dut (
    .clock(clock), .reset(reset), .pc(pc), .instrmem_rd(instrmem_rd),
    .Instr_dout(Instr_dout), .complete_instr(complete_instr),
    .Data_en(Data_en), .Data_addr(Data_addr), .Data_rd(Data_rd),
    .Data_din(Data_din), .Data_dout(Data_dout), .complete_data(complete_data),
    .cfg_instr_lat(cfg_instr_lat), .cfg_data_lat(cfg_data_lat),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .instr_cnt(instr_cnt), .data_cnt(data_cnt)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] mem_m [4096];
  logic [15:0] icnt_m = 16'h0;
  logic [15:0] dcnt_m = 16'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_word(input logic [15:0] a, input logic [15:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en = 1'b0;
    mem_m[a[11:0]] = d;
  endtask

  function automatic logic [15:0] mk_addr(input int idx);
    logic [3:0] hi;
    hi = 4'($urandom);
    return {hi, 12'(idx)};
  endfunction

  task automatic data_txn(input logic rd, input logic [15:0] a, input logic [15:0] din,
                          input logic [3:0] lat);
    logic [15:0] prev;
    logic [15:0] exp;
    int waited;
    prev         = Data_dout;
    cfg_data_lat = lat;
    Data_en      = 1'b1;
    Data_rd      = rd;
    Data_addr    = a;
    Data_din     = din;
    tick();
    Data_en      = 1'b0;
    Data_addr    = 16'($urandom);
    Data_din     = 16'($urandom);
    Data_rd      = 1'($urandom);
    cfg_data_lat = 4'($urandom);
    waited = 1;
    while (!complete_data && waited < 20) begin
      tick();
      waited++;
    end
    check("data_latency", waited, int'(lat) + 1);
    exp = rd ? mem_m[a[11:0]] : prev;
    check(rd ? "data_read" : "data_write_hold", Data_dout, exp);
    if (!rd) mem_m[a[11:0]] = din;
    dcnt_m++;
    check("data_cnt", data_cnt, dcnt_m);
    tick();
    check("data_pulse_end", complete_data, 1'b0);
    check("data_dout_hold", Data_dout, exp);
  endtask

  task automatic instr_txn(input logic [15:0] a, input logic [3:0] lat);
    logic [15:0] exp;
    int waited;
    cfg_instr_lat = lat;
    instrmem_rd   = 1'b1;
    pc            = a;
    tick();
    instrmem_rd   = 1'b0;
    pc            = 16'($urandom);
    cfg_instr_lat = 4'($urandom);
    waited = 1;
    while (!complete_instr && waited < 20) begin
      tick();
      waited++;
    end
    check("instr_latency", waited, int'(lat) + 1);
    exp = mem_m[a[11:0]];
    check("instr_read", Instr_dout, exp);
    icnt_m++;
    check("instr_cnt", instr_cnt, icnt_m);
    tick();
    check("instr_pulse_end", complete_instr, 1'b0);
    check("instr_dout_hold", Instr_dout, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic seen;
    reset = 1'b0; pc = 16'h0; instrmem_rd = 1'b0;
    Data_en = 1'b0; Data_addr = 16'h0; Data_rd = 1'b0; Data_din = 16'h0;
    cfg_instr_lat = 4'd0; cfg_data_lat = 4'd0;
    load_en = 1'b0; load_addr = 16'h0; load_data = 16'h0;
    tick(); tick();
    check("rst_complete_instr", complete_instr, 1'b0);
    check("rst_complete_data", complete_data, 1'b0);
    check("rst_instr_dout", Instr_dout, 16'h0);
    check("rst_data_dout", Data_dout, 16'h0);
    check("rst_instr_cnt", instr_cnt, 16'h0);
    check("rst_data_cnt", data_cnt, 16'h0);
    reset = 1'b1;
    tick();

    // Streaming zero-latency fetch
    load_word(16'h3000, 16'h1261);
    cfg_instr_lat = 4'd0;
    pc            = 16'h3000;
    instrmem_rd   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      icnt_m++;
      check("stream_complete", complete_instr, 1'b1);
      check("stream_dout", Instr_dout, 16'h1261);
      check("stream_cnt", instr_cnt, icnt_m);
    end
    instrmem_rd = 1'b0;
    tick();
    check("stream_stop", complete_instr, 1'b0);
    check("stream_hold", Instr_dout, 16'h1261);

    // Data read with wait states, write then read-back
    load_word(16'h3005, 16'hBEEF);
    data_txn(1'b1, 16'h3005, 16'h0000, 4'd3);
    data_txn(1'b0, 16'h3010, 16'hA5A5, 4'd2);
    data_txn(1'b1, 16'h3010, 16'h0000, 4'd1);
    check("wr_rd_back", Data_dout, 16'hA5A5);

    // Preload and data write to the same word on the same edge
    cfg_data_lat = 4'd0;
    Data_en = 1'b1; Data_rd = 1'b0; Data_addr = 16'h3020; Data_din = 16'h2222;
    load_en = 1'b1; load_addr = 16'h3020; load_data = 16'h1111;
    tick();
    load_en = 1'b0; Data_en = 1'b0;
    check("same_edge_complete", complete_data, 1'b1);
    dcnt_m++;
    mem_m[12'h020] = 16'h1111;
    tick();
    data_txn(1'b1, 16'h3020, 16'h0000, 4'd0);
    check("load_priority", Data_dout, 16'h1111);

    // Reset aborts an in-flight write
    load_word(16'h3030, 16'h5A5A);
    cfg_data_lat = 4'd5;
    Data_en = 1'b1; Data_rd = 1'b0; Data_addr = 16'h3030; Data_din = 16'hDEAD;
    tick();
    Data_en = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("abort_complete_data", complete_data, 1'b0);
    check("abort_complete_instr", complete_instr, 1'b0);
    check("abort_data_dout", Data_dout, 16'h0);
    check("abort_instr_dout", Instr_dout, 16'h0);
    check("abort_data_cnt", data_cnt, 16'h0);
    check("abort_instr_cnt", instr_cnt, 16'h0);
    icnt_m = 16'h0;
    dcnt_m = 16'h0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen = seen | complete_data;
    end
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen = seen | complete_data;
    end
    check("abort_no_pulse", seen, 1'b0);
    data_txn(1'b1, 16'h3030, 16'h0000, 4'd0);
    check("abort_no_write", Data_dout, 16'h5A5A);

    // Upper address bits alias onto the same word
    load_word(16'h4000, 16'h7777);
    instr_txn(16'h3000, 4'd0);
    check("alias_fetch", Instr_dout, 16'h7777);

    // Randomized: fetches on indices 0..63, data traffic on 64..127, run concurrently
    for (int i = 0; i < 128; i++) load_word(mk_addr(i), 16'($urandom));
    for (int t = 0; t < 40; t++) begin
      logic [15:0] ia, da, dd;
      logic [3:0]  il, dl;
      logic        drd;
      ia  = mk_addr($urandom_range(63, 0));
      da  = mk_addr($urandom_range(127, 64));
      dd  = 16'($urandom);
      drd = 1'($urandom);
      il  = 4'($urandom_range(15, 0));
      dl  = 4'($urandom_range(15, 0));
      fork
        instr_txn(ia, il);
        data_txn(drd, da, dd, dl);
      join
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
